// File: rtl/chip_draw_sched.sv
// Round-robin draw scheduler: arbitrates two cell-draw requesters, maps the board
// cell to a pixel origin and sweeps a 16x16 sprite ROM into one VGA plot per cycle.
module chip_draw_sched #(
  parameter int CELL_W   = 16,
  parameter int BOARD_X0 = 24,
  parameter int BOARD_Y0 = 16,
  parameter int COLS     = 7,
  parameter int ROWS     = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_a,
  input  logic [2:0] a_col,
  input  logic [2:0] a_row,
  input  logic [1:0] a_player,
  input  logic       req_b,
  input  logic [2:0] b_col,
  input  logic [2:0] b_row,
  input  logic [1:0] b_player,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] rom_sel,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_q,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [7:0] colour,
  output logic       plot
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_FLUSH, S_DONE} state_t;

  localparam logic [3:0] LC_COLS = 4'(COLS);
  localparam logic [3:0] LC_ROWS = 4'(ROWS);
  localparam logic [7:0] LC_X0   = 8'(BOARD_X0);
  localparam logic [6:0] LC_Y0   = 7'(BOARD_Y0);
  localparam logic [6:0] LC_RM1  = 7'(ROWS - 1);
  localparam logic [7:0] LC_CW8  = 8'(CELL_W);
  localparam logic [6:0] LC_CW7  = 7'(CELL_W);

  state_t     r_state;
  logic       r_last_b;
  logic       r_gnt_a, r_gnt_b, r_busy, r_done, r_err, r_plot;
  logic [1:0] r_sel;
  logic [7:0] r_addr;
  logic [7:0] r_x0;
  logic [6:0] r_y0;
  logic [7:0] r_cnt_d;
  logic       r_vld_d;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [7:0] r_colour;

  logic       w_pick_a, w_pick_b;
  logic [2:0] w_col, w_row;
  logic [1:0] w_player;
  logic       w_bad;
  logic [7:0] w_x0;
  logic [6:0] w_y0;

  // A wins a tie only when B was granted last; a lone request always wins.
  assign w_pick_a = req_a & (~req_b | r_last_b);
  assign w_pick_b = req_b & ~w_pick_a;
  assign w_col    = w_pick_a ? a_col    : b_col;
  assign w_row    = w_pick_a ? a_row    : b_row;
  assign w_player = w_pick_a ? a_player : b_player;
  assign w_bad    = ({1'b0, w_col} >= LC_COLS) | ({1'b0, w_row} >= LC_ROWS);

  // Row 0 is the bottom row, so screen y grows as the row index falls.
  assign w_x0 = LC_X0 + 8'(w_col) * LC_CW8;
  assign w_y0 = LC_Y0 + (LC_RM1 - 7'(w_row)) * LC_CW7;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_last_b <= 1'b1;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_plot   <= 1'b0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_cnt_d  <= '0;
      r_vld_d  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      // Second pipe stage: ROM data for cnt_d arrives this cycle.
      r_plot  <= r_vld_d;
      if (r_vld_d) begin
        r_x      <= r_x0 + {4'b0, r_cnt_d[3:0]};
        r_y      <= r_y0 + {3'b0, r_cnt_d[7:4]};
        r_colour <= rom_q;
      end
      case (r_state)
        S_IDLE: begin
          if (req_a | req_b) begin
            r_gnt_a  <= w_pick_a;
            r_gnt_b  <= w_pick_b;
            r_last_b <= w_pick_b;
            r_sel    <= w_player;
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_x0    <= w_x0;
              r_y0    <= w_y0;
              r_addr  <= '0;
              r_busy  <= 1'b1;
              r_state <= S_SWEEP;
            end
          end
        end
        S_SWEEP: begin
          r_cnt_d <= r_addr;
          r_vld_d <= 1'b1;
          if (r_addr == 8'hFF) r_state <= S_FLUSH;
          else                 r_addr  <= r_addr + 8'd1;
        end
        S_FLUSH: begin
          r_vld_d <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_a    = r_gnt_a;
  assign gnt_b    = r_gnt_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign rom_sel  = r_sel;
  assign rom_addr = r_addr;
  assign x        = r_x;
  assign y        = r_y;
  assign colour   = r_colour;
  assign plot     = r_plot;

endmodule

// File: tb/tb_chip_draw_sched.sv
// Directed bench for chip_draw_sched: vector table of single requests plus
// sequences for arbitration, mid-sweep reset and requests queued behind a sweep.
module tb_chip_draw_sched;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_a, req_b;
  logic [2:0] a_col, a_row, b_col, b_row;
  logic [1:0] a_player, b_player;
  logic       gnt_a, gnt_b, busy, done, err, plot;
  logic [1:0] rom_sel;
  logic [7:0] rom_addr, rom_q, x, colour;
  logic [6:0] y;

  int npass = 0;
  int ntot  = 0;

  chip_draw_sched dut (
    .clk(clk), .resetn(resetn),
    .req_a(req_a), .a_col(a_col), .a_row(a_row), .a_player(a_player),
    .req_b(req_b), .b_col(b_col), .b_row(b_row), .b_player(b_player),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .done(done), .err(err),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_q(rom_q),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  // Synchronous ROM returning its address as data.
  always @(posedge clk) rom_q <= rom_addr;

  typedef struct {
    logic       is_a;
    logic [2:0] col;
    logic [2:0] row;
    logic [1:0] pl;
    logic       exp_err;
    int         ex0;
    int         ey0;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (gnt_a | gnt_b) break;
      if (n > 600) begin
        chk("gnt_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Called in the gnt cycle; returns in the done cycle.
  task automatic run_sweep(input string nm, input int ex0, input int ey0, input int esel);
    int c, first, last, nplots, gaps, pixbad, busybad, selbad, done_c, busy_at_done, lx, ly;
    first = -1; last = -1; nplots = 0; gaps = 0; pixbad = 0; busybad = 0; selbad = 0;
    done_c = -1; busy_at_done = -1; lx = -1; ly = -1;
    chk({nm, "_busy_at_gnt"}, int'(busy), 1);
    chk({nm, "_rom_sel"}, int'(rom_sel), esel);
    for (c = 1; c < 400; c++) begin
      tick();
      if (rom_sel != 2'(esel)) selbad++;
      if (plot) begin
        if (first < 0) first = c;
        if (last >= 0 && last != c - 1) gaps++;
        if (int'(x) != ex0 + nplots % 16 || int'(y) != ey0 + nplots / 16 ||
            int'(colour) != nplots % 256) begin
          if (pixbad == 0)
            $display("FAIL %s_pixel: plot %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", nm, nplots,
                     x, y, colour, ex0 + nplots % 16, ey0 + nplots / 16, nplots % 256);
          pixbad++;
        end
        if (!busy) busybad++;
        nplots++;
        last = c;
        lx = int'(x);
        ly = int'(y);
      end
      if (done) begin
        done_c = c;
        busy_at_done = int'(busy);
        break;
      end
    end
    ntot++;
    if (pixbad == 0) npass++;
    chk({nm, "_first_latency"}, first, 2);
    chk({nm, "_nplots"}, nplots, 256);
    chk({nm, "_gaps"}, gaps, 0);
    chk({nm, "_last_x"}, lx, ex0 + 15);
    chk({nm, "_last_y"}, ly, ey0 + 15);
    chk({nm, "_busy_during"}, busybad, 0);
    chk({nm, "_sel_stable"}, selbad, 0);
    chk({nm, "_done_after_last"}, done_c, last + 1);
    chk({nm, "_busy_at_done"}, busy_at_done, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #12;
    chk("reset_outputs", int'({gnt_a, gnt_b, busy, done, err, plot, rom_sel, rom_addr, x, y, colour}), 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int n, pc, quiet_plots, quiet_busy;
    resetn = 1'b1;
    req_a = 0; req_b = 0;
    a_col = 0; a_row = 0; a_player = 0;
    b_col = 0; b_row = 0; b_player = 0;

    vt[0] = '{1'b1, 3'd0, 3'd5, 2'd1, 1'b0, 24, 16};
    vt[1] = '{1'b1, 3'd6, 3'd0, 2'd2, 1'b0, 120, 96};
    vt[2] = '{1'b0, 3'd3, 3'd2, 2'd3, 1'b0, 72, 64};
    vt[3] = '{1'b0, 3'd7, 3'd2, 2'd1, 1'b1, 0, 0};
    vt[4] = '{1'b1, 3'd2, 3'd6, 2'd2, 1'b1, 0, 0};
    vt[5] = '{1'b1, 3'd0, 3'd0, 2'd0, 1'b0, 24, 96};
    vt[6] = '{1'b0, 3'd6, 3'd5, 2'd1, 1'b0, 120, 16};

    #3;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      tick();
      if (vt[i].is_a) begin
        req_a = 1; a_col = vt[i].col; a_row = vt[i].row; a_player = vt[i].pl;
      end else begin
        req_b = 1; b_col = vt[i].col; b_row = vt[i].row; b_player = vt[i].pl;
      end
      wait_gnt(n);
      chk($sformatf("v%0d_gnt_a", i), int'(gnt_a), int'(vt[i].is_a));
      chk($sformatf("v%0d_gnt_b", i), int'(gnt_b), int'(!vt[i].is_a));
      chk($sformatf("v%0d_err", i), int'(err), int'(vt[i].exp_err));
      req_a = 0; req_b = 0;
      if (vt[i].exp_err) begin
        quiet_plots = 0; quiet_busy = 0;
        for (int k = 0; k < 20; k++) begin
          if (plot) quiet_plots++;
          if (busy) quiet_busy++;
          tick();
        end
        chk($sformatf("v%0d_err_plots", i), quiet_plots, 0);
        chk($sformatf("v%0d_err_busy", i), quiet_busy, 0);
      end else begin
        run_sweep($sformatf("v%0d", i), vt[i].ex0, vt[i].ey0, int'(vt[i].pl));
      end
    end

    // Both requesters held: grants alternate A,B,A with one idle cycle between bursts.
    do_reset();
    tick();
    req_a = 1; a_col = 3'd1; a_row = 3'd1; a_player = 2'd1;
    req_b = 1; b_col = 3'd5; b_row = 3'd4; b_player = 2'd2;
    wait_gnt(n);
    chk("rr0_gnt_a", int'(gnt_a), 1);
    run_sweep("rr0", 40, 80, 1);
    wait_gnt(n);
    chk("rr1_gap", n, 1);
    chk("rr1_gnt_b", int'(gnt_b), 1);
    run_sweep("rr1", 104, 32, 2);
    wait_gnt(n);
    chk("rr2_gap", n, 1);
    chk("rr2_gnt_a", int'(gnt_a), 1);
    run_sweep("rr2", 40, 80, 1);
    req_a = 0; req_b = 0;

    // Reset at plot #100 aborts the sweep; nothing plots afterwards.
    tick();
    req_a = 1; a_col = 3'd4; a_row = 3'd3; a_player = 2'd3;
    wait_gnt(n);
    req_a = 0;
    pc = 0;
    for (int k = 0; k < 200 && pc < 100; k++) begin
      tick();
      if (plot) pc++;
    end
    chk("mid_reached_100", pc, 100);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_async_zero", int'({plot, busy, x, y}), 0);
    #2;
    resetn = 1'b1;
    quiet_plots = 0; quiet_busy = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (plot) quiet_plots++;
      if (busy) quiet_busy++;
    end
    chk("post_reset_plots", quiet_plots, 0);
    chk("post_reset_busy", quiet_busy, 0);

    // A arrives during B's sweep and changes operands before it is granted.
    req_b = 1; b_col = 3'd2; b_row = 3'd0; b_player = 2'd3;
    wait_gnt(n);
    chk("q_gnt_b", int'(gnt_b), 1);
    req_b = 0;
    req_a = 1; a_col = 3'd0; a_row = 3'd0; a_player = 2'd1;
    fork
      begin
        repeat (50) @(posedge clk);
        #2;
        a_col = 3'd5; a_row = 3'd1; a_player = 2'd2;
      end
    join_none
    run_sweep("q_b", 56, 96, 3);
    wait_gnt(n);
    chk("q_a_after_done", n, 1);
    chk("q_gnt_a", int'(gnt_a), 1);
    req_a = 0;
    run_sweep("q_a", 104, 80, 2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
